spi_slave_core: RTL and testbench

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_define.sv | 9 +
 rtl/spi_slave_sync.sv | 20 ++
 rtl/spi_slave_core.sv | 115 +++++++++++
 tb/tb_spi_slave_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_define.sv
// spi_define: shared widths, FSM state type and bit-select helper for the SPI slave
package spi_define;
    localparam int SPI_DATA_WIDTH = 32;
    localparam int SPI_CNT_W = 6;
    typedef enum logic {IDLE, ACTIVE} spi_state_t;
    function automatic logic out_bit(input logic [SPI_DATA_WIDTH-1:0] v, input logic lsb, input logic [4:0] top);
        return lsb ? v[0] : v[top];
    endfunction
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-flop pad synchronizer with rise/fall pulses on the synchronized value
module spi_slave_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= {3{RST_VAL}};
        else     s <= {s[1:0], d};
    end
    assign q    = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave, modes 0-3, 8/16/24/32-bit words, tx holding reg and rx handshake
module spi_slave_core
    import spi_define::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpol_i,
    input  logic                      cpha_i,
    input  logic                      lsb_i,
    input  logic [1:0]                dtb_i,
    input  logic                      spi_sck_i,
    input  logic                      spi_nss_i,
    input  logic                      spi_mosi_i,
    output logic                      spi_miso_o,
    output logic                      spi_miso_en_o,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data_i,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [SPI_DATA_WIDTH-1:0] rx_data_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic                      underrun_o
);
    logic sck_q, sck_rise, sck_fall, nss_q, nss_rise, nss_fall, mosi_q, mosi_rise, mosi_fall;
    logic unused_sync;
    spi_slave_sync #(.RST_VAL(1'b0)) u_sck  (.clk(clk_i), .rst(rst_i), .d(spi_sck_i),  .q(sck_q),  .rise(sck_rise),  .fall(sck_fall));
    spi_slave_sync #(.RST_VAL(1'b1)) u_nss  (.clk(clk_i), .rst(rst_i), .d(spi_nss_i),  .q(nss_q),  .rise(nss_rise),  .fall(nss_fall));
    spi_slave_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk_i), .rst(rst_i), .d(spi_mosi_i), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
    assign unused_sync = ^{sck_q, nss_q, mosi_rise, mosi_fall};

    spi_state_t                state;
    logic [SPI_CNT_W-1:0]      cnt;
    logic [SPI_DATA_WIDTH-1:0] rx_sh, tx_sh, hold, rx_nx, tx_ld, tx_sft;
    logic                      hold_v, miso_r;
    logic [4:0]                top_bit;
    logic                      lead, trail, act, smp, drv, done, load;

    assign top_bit = {dtb_i, 3'b111};
    assign lead    = cpol_i ? sck_fall : sck_rise;
    assign trail   = cpol_i ? sck_rise : sck_fall;
    assign act     = state == ACTIVE && !nss_rise;
    assign smp     = act && (cpha_i ? trail : lead);
    assign drv     = act && (cpha_i ? lead : trail);
    assign done    = smp && cnt == {1'b0, top_bit};
    assign load    = (state == IDLE && nss_fall) || done;
    // LSB-first words fill from the top of the active width downward
    assign rx_nx   = lsb_i ? (rx_sh >> 1) | ({31'b0, mosi_q} << top_bit) : {rx_sh[30:0], mosi_q};
    assign tx_ld   = hold_v ? hold : '0;
    assign tx_sft  = lsb_i ? tx_sh >> 1 : tx_sh << 1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            hold       <= '0;
            hold_v     <= 1'b0;
            miso_r     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
            if (nss_rise) begin
                state  <= IDLE;
                cnt    <= '0;
                rx_sh  <= '0;
                tx_sh  <= '0;
                miso_r <= 1'b0;
            end else if (state == IDLE && nss_fall) begin
                state <= ACTIVE;
            end
            if (smp) begin
                cnt   <= done ? '0 : cnt + 6'd1;
                rx_sh <= done ? '0 : rx_nx;
            end
            // mode 0/2 skips the trailing edge after the final sample: the next word is already presented
            if (drv && cpha_i) begin
                miso_r <= out_bit(tx_sh, lsb_i, top_bit);
                tx_sh  <= tx_sft;
            end else if (drv && cnt != '0) begin
                miso_r <= out_bit(tx_sft, lsb_i, top_bit);
                tx_sh  <= tx_sft;
            end
            if (load) begin
                tx_sh      <= tx_ld;
                hold_v     <= 1'b0;
                underrun_o <= !hold_v;
                if (!cpha_i) miso_r <= out_bit(tx_ld, lsb_i, top_bit);
            end
            if (tx_valid_i && !hold_v) begin
                hold   <= tx_data_i;
                hold_v <= 1'b1;
            end
            if (done && (!rx_valid_o || rx_ready_i)) begin
                rx_data_o  <= rx_nx;
                rx_valid_o <= 1'b1;
            end else if (done) begin
                overrun_o <= 1'b1;
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o        = state == ACTIVE;
    assign spi_miso_en_o = busy_o;
    assign spi_miso_o    = busy_o & miso_r;
    assign tx_ready_o    = !hold_v;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: bench acting as SPI master against a word-level reference of the slave
module tb_spi_slave_core;
    localparam int H = 8;
    logic        clk = 1'b0, rst_i = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic [1:0]  dtb = 2'd0;
    logic        sck = 1'b0, nss = 1'b1, mosi = 1'b0;
    logic        miso, miso_en, tx_ready, rx_valid, busy, overrun, underrun;
    logic        tx_valid = 1'b0, rx_ready = 1'b0;
    logic [31:0] tx_data = '0, rx_data;
    int          errors = 0, checks = 0, ovr = 0, und = 0;
    logic [31:0] mo [4];
    logic [31:0] mi [4];

    spi_slave_core dut (
        .clk_i(clk), .rst_i(rst_i), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb), .dtb_i(dtb),
        .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi), .spi_miso_o(miso), .spi_miso_en_o(miso_en),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
        .busy_o(busy), .overrun_o(overrun), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (overrun) ovr <= ovr + 1;
        if (underrun) und <= und + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] wmask();
        return 32'((64'd1 << (8 * (int'(dtb) + 1))) - 64'd1);
    endfunction

    task automatic tx_write(input logic [31:0] v);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Master: nw words of 8*(dtb+1) bits, stopping after stop_at bits when stop_at >= 0
    task automatic xfer(input int nw, input int stop_at);
        int n, k, b;
        n = 8 * (int'(dtb) + 1);
        k = 0;
        sck = cpol;
        wait_clk(H);
        nss = 1'b0;
        wait_clk(H);
        for (int w = 0; w < nw; w++) begin
            mi[w] = '0;
            for (int i = 0; i < n; i++) begin
                if (stop_at < 0 || k < stop_at) begin
                    b = lsb ? i : n - 1 - i;
                    if (!cpha) begin
                        mosi = mo[w][b];
                        wait_clk(H);
                        mi[w][b] = miso;
                        sck = ~sck;
                        wait_clk(H);
                        sck = ~sck;
                    end else begin
                        sck = ~sck;
                        mosi = mo[w][b];
                        wait_clk(H);
                        mi[w][b] = miso;
                        sck = ~sck;
                        wait_clk(H);
                    end
                    k++;
                end
            end
        end
        wait_clk(H);
        nss = 1'b1;
        wait_clk(H);
    endtask

    initial begin
        int u0, o0;
        logic [31:0] tx, m;
        wait_clk(3);
        chk("reset_flags", {25'b0, busy, miso_en, miso, tx_ready, rx_valid, overrun, underrun}, 32'h08);
        chk("reset_rx_data", rx_data, 32'h0);
        rst_i = 1'b0;
        wait_clk(4);
        chk("idle_flags", {25'b0, busy, miso_en, miso, tx_ready, rx_valid, overrun, underrun}, 32'h08);

        tx_write(32'hA5);
        mo[0] = 32'h3C;
        xfer(1, -1);
        chk("m0_miso", mi[0], 32'hA5);
        chk("m0_rx_data", rx_data, 32'h3C);
        chk("m0_rx_valid", {31'b0, rx_valid}, 32'd1);
        chk("m0_busy_after", {31'b0, busy}, 32'd0);
        consume();
        chk("m0_rx_consumed", {31'b0, rx_valid}, 32'd0);

        cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; dtb = 2'd3;
        tx_write(32'h12345678);
        mo[0] = 32'hDEADBEEF;
        xfer(1, -1);
        chk("m3_miso", mi[0], 32'h12345678);
        chk("m3_rx_data", rx_data, 32'hDEADBEEF);
        chk("m3_rx_valid", {31'b0, rx_valid}, 32'd1);
        consume();

        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dtb = 2'd0;
        o0 = ovr;
        mo[0] = 32'h11; mo[1] = 32'h22;
        xfer(2, -1);
        chk("ovr_pulses", 32'(ovr - o0), 32'd1);
        chk("ovr_rx_data", rx_data, 32'h11);
        chk("ovr_rx_valid", {31'b0, rx_valid}, 32'd1);
        consume();

        cpha = 1'b1;
        u0 = und;
        mo[0] = 32'h5A;
        xfer(1, -1);
        chk("und_miso", mi[0], 32'h0);
        chk("und_pulses", 32'(und - u0), 32'd2);
        chk("und_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("und_rx_data", rx_data, 32'h5A);
        consume();

        cpha = 1'b0; dtb = 2'd1;
        mo[0] = 32'hFFFF;
        xfer(1, 5);
        chk("abort_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        tx_write(32'hC3A5);
        mo[0] = 32'hBEEF;
        xfer(1, -1);
        chk("abort_next_miso", mi[0], 32'hC3A5);
        chk("abort_next_rx", rx_data, 32'hBEEF);
        consume();

        cpol = 1'b1; cpha = 1'b0; dtb = 2'd0;
        mo[0] = 32'h96;
        xfer(1, -1);
        chk("m2_rx_pending", rx_data, 32'h96);
        sck = 1'b1;
        nss = 1'b0;
        wait_clk(H);
        tx_write(32'h77);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            wait_clk(H);
            sck = ~sck;
            wait_clk(H);
            sck = ~sck;
        end
        chk("m2_busy_mid", {31'b0, busy}, 32'd1);
        rst_i = 1'b1;
        nss = 1'b1;
        #1;
        chk("rst_mid_flags", {25'b0, busy, miso_en, miso, tx_ready, rx_valid, overrun, underrun}, 32'h08);
        chk("rst_mid_rx_data", rx_data, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        wait_clk(4);
        chk("rst_after_flags", {25'b0, busy, miso_en, miso, tx_ready, rx_valid, overrun, underrun}, 32'h08);
        tx_write(32'h3C);
        mo[0] = 32'h81;
        xfer(1, -1);
        chk("rst_next_miso", mi[0], 32'h3C);
        chk("rst_next_rx", rx_data, 32'h81);
        consume();

        for (int r = 0; r < 6; r++) begin
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            lsb  = 1'($urandom_range(0, 1));
            dtb  = 2'($urandom_range(0, 3));
            tx    = $urandom;
            mo[0] = $urandom;
            m     = wmask();
            tx_write(tx);
            xfer(1, -1);
            chk("rand_miso", mi[0], tx & m);
            chk("rand_rx_data", rx_data, mo[0] & m);
            chk("rand_rx_valid", {31'b0, rx_valid}, 32'd1);
            consume();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
